cycle_seq: RTL and testbench
============================

CYCLE_SEQ -- requirements
Module: cycle_seq

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port PH1  input  1  phase-1 strobe from the two-phase clock generator, sampled synchronously on CLK.
REQ-004 SHALL have port PH2  input  1  phase-2 strobe, sampled synchronously on CLK; the state-advance qualifier.
REQ-005 SHALL have port READY  input  1  memory ready for instruction fetch.
REQ-006 SHALL have port LONG  input  1  decoded instruction needs a second execute cycle.
REQ-007 SHALL have port HALT  input  1  halt request, honoured only in FETCH.
REQ-008 SHALL have port STATE  output  2  current machine state: 00 FETCH, 01 DECODE, 10 EXEC, 11 EXEC2.
REQ-009 SHALL have port SYNC  output  1  registered; high for one CLK after each PH1 strobe seen in FETCH.
REQ-010 SHALL have port PC_INC  output  1  one-CLK pulse per accepted fetch.
REQ-011 SHALL have port WB_EN  output  1  one-CLK write-back pulse on leaving the final execute state.
REQ-012 SHALL have port HALTED  output  1  processor held in FETCH by HALT.
REQ-013 SHALL have port ICOUNT  output  4  completed-instruction counter.

Function
REQ-014 SHALL define an advance tick as a CLK edge with PH2=1; STATE SHALL change only on advance ticks.
REQ-015 SHALL give PH2 precedence if PH1 and PH2 are both 1 (illegal overlap): edge is an advance tick, PH1 ignored that cycle.
REQ-016 FETCH: on a tick with READY=1 and HALT=0 -> DECODE, and PC_INC=1 for the following CLK cycle only.
REQ-017 FETCH: on a tick with READY=0 -> remain FETCH, no PC_INC.
REQ-018 FETCH: on a tick with HALT=1 -> remain FETCH, HALTED=1 from the next edge; HALT beats READY.
REQ-019 HALTED SHALL clear on the first tick with HALT=0, on the same edge the FETCH->DECODE transition is evaluated.
REQ-020 DECODE: LONG SHALL be latched on any CLK edge in DECODE with PH1=1; on the tick -> EXEC unconditionally.
REQ-021 EXEC: on a tick -> EXEC2 if latched LONG=1, else -> FETCH with WB_EN=1 for one CLK.
REQ-022 EXEC2: on a tick -> FETCH with WB_EN=1 for one CLK; latched LONG cleared.
REQ-023 ICOUNT SHALL increment by 1 on each WB_EN edge, modulo 16 (15 -> 0 wrap, no flag).
REQ-024 SYNC SHALL be 1 in the CLK after an edge with STATE=FETCH, PH1=1, PH2=0, otherwise 0.
REQ-025 Minimum instruction length SHALL be 3 ticks (short), 4 ticks (long), plus READY/HALT stall ticks.
REQ-026 Non-tick edges SHALL hold STATE, HALTED, ICOUNT; PC_INC, WB_EN and SYNC SHALL return to 0.

Reset
REQ-027 RST=1 SHALL asynchronously force STATE=00, SYNC=0, PC_INC=0, WB_EN=0, HALTED=0, ICOUNT=0, latched LONG=0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no WB_EN and no ICOUNT increment.
REQ-029 After RST deasserts, the first advance tick SHALL be evaluated as FETCH.

Verification
REQ-030 Reset, then 3 short instructions with READY=1, LONG=0 -> STATE 00,01,10,00 per tick; 3 PC_INC and 3 WB_EN pulses; ICOUNT=3.
REQ-031 LONG=1 held with PH1 during DECODE -> STATE 00,01,10,11,00; WB_EN only on the EXEC2->FETCH edge; next instruction with LONG=0 takes 3 ticks.
REQ-032 READY=0 for 2 ticks in FETCH, then 1 -> 2 extra FETCH ticks, no PC_INC until READY=1, then single PC_INC.
REQ-033 HALT=1 with READY=1 for 4 ticks -> STATE stays 00, HALTED=1, no PC_INC; HALT=0 -> HALTED=0 and DECODE on that tick.
REQ-034 Run 17 short instructions -> ICOUNT wraps 15->0->1; then RST pulsed in EXEC -> all outputs 0 immediately, no WB_EN.
REQ-035 Drive PH1=PH2=1 on one edge in FETCH with READY=1 -> treated as tick (-> DECODE), SYNC stays 0.

Source files
------------

// File: rtl/cycle_seq.sv
// Two-phase-strobed instruction cycle sequencer: FETCH -> DECODE -> EXEC [-> EXEC2] -> FETCH.
// PH2 is the advance qualifier; PH1 drives SYNC and the LONG capture window.
module cycle_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PH1,
  input  logic       PH2,
  input  logic       READY,
  input  logic       LONG,
  input  logic       HALT,
  output logic [1:0] STATE,
  output logic       SYNC,
  output logic       PC_INC,
  output logic       WB_EN,
  output logic       HALTED,
  output logic [3:0] ICOUNT
);

  localparam logic [1:0] FETCH  = 2'b00;
  localparam logic [1:0] DECODE = 2'b01;
  localparam logic [1:0] EXEC   = 2'b10;
  localparam logic [1:0] EXEC2  = 2'b11;

  logic       tick;
  logic       ph1_only;
  logic       long_q;
  logic       fetch_go;
  logic       retire;
  logic [1:0] state_nx;

  // PH2 wins an illegal PH1/PH2 overlap, so PH1 only counts when PH2 is low.
  assign tick     = PH2;
  assign ph1_only = PH1 & ~PH2;

  always_comb begin
    state_nx = STATE;
    fetch_go = 1'b0;
    retire   = 1'b0;
    if (tick) begin
      case (STATE)
        FETCH: begin
          if (READY && !HALT) begin
            state_nx = DECODE;
            fetch_go = 1'b1;
          end
        end
        DECODE: state_nx = EXEC;
        EXEC: begin
          if (long_q) begin
            state_nx = EXEC2;
          end else begin
            state_nx = FETCH;
            retire   = 1'b1;
          end
        end
        EXEC2: begin
          state_nx = FETCH;
          retire   = 1'b1;
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STATE  <= FETCH;
      SYNC   <= 1'b0;
      PC_INC <= 1'b0;
      WB_EN  <= 1'b0;
      HALTED <= 1'b0;
      ICOUNT <= '0;
      long_q <= 1'b0;
    end else begin
      STATE  <= state_nx;
      SYNC   <= (STATE == FETCH) && ph1_only;
      PC_INC <= fetch_go;
      WB_EN  <= retire;
      if (retire)
        ICOUNT <= ICOUNT + 4'd1;
      // HALT is only sampled on FETCH ticks, so HALTED holds across non-tick edges.
      if (tick && (STATE == FETCH))
        HALTED <= HALT;
      if ((STATE == DECODE) && ph1_only)
        long_q <= LONG;
      else if (tick && (STATE == EXEC2))
        long_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cycle_seq.sv
module tb_cycle_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       ready = 1'b0;
  logic       long_in = 1'b0;
  logic       halt = 1'b0;
  logic [1:0] state;
  logic       sync;
  logic       pc_inc;
  logic       wb_en;
  logic       halted;
  logic [3:0] icount;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [9:0] exp_q[$];
  string      name_q[$];
  event       chk_ev;

  cycle_seq dut (
    .CLK(clk), .RST(rst), .PH1(ph1), .PH2(ph2), .READY(ready), .LONG(long_in), .HALT(halt),
    .STATE(state), .SYNC(sync), .PC_INC(pc_inc), .WB_EN(wb_en), .HALTED(halted), .ICOUNT(icount)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input int s, input int sy, input int pc, input int wb,
                                    input int h, input int ic);
    return {s[1:0], sy[0], pc[0], wb[0], h[0], ic[3:0]};
  endfunction

  initial begin
    logic [9:0] e;
    logic [9:0] a;
    string      nm;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {state, sync, pc_inc, wb_en, halted, icount};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got st=%b sync=%b pc=%b wb=%b halted=%b ic=%0d, expected st=%b sync=%b pc=%b wb=%b halted=%b ic=%0d",
                   nm, a[9:8], a[7], a[6], a[5], a[4], a[3:0],
                   e[9:8], e[7], e[6], e[5], e[4], e[3:0]);
        end
      end
    end
  end

  task automatic step(input int r, input int p1, input int p2, input int rd, input int lg,
                      input int hl, input logic [9:0] e, input string nm);
    @(negedge clk);
    rst     = r[0];
    ph1     = p1[0];
    ph2     = p2[0];
    ready   = rd[0];
    long_in = lg[0];
    halt    = hl[0];
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic decode_exec(input int lg, input int ic);
    int n;
    n = (ic + 1) % 16;
    step(0, 1, 0, 1, lg, 0, mk(1, 0, 0, 0, 0, ic), "decode_ph1");
    step(0, 0, 1, 1, 0, 0, mk(2, 0, 0, 0, 0, ic), "decode_tick");
    if (lg != 0) begin
      step(0, 1, 0, 1, 0, 0, mk(2, 0, 0, 0, 0, ic), "exec_ph1");
      step(0, 0, 1, 1, 0, 0, mk(3, 0, 0, 0, 0, ic), "exec_to_exec2");
      step(0, 1, 0, 1, 0, 0, mk(3, 0, 0, 0, 0, ic), "exec2_ph1");
      step(0, 0, 1, 1, 0, 0, mk(0, 0, 0, 1, 0, n),  "exec2_retire");
    end else begin
      step(0, 1, 0, 1, 0, 0, mk(2, 0, 0, 0, 0, ic), "exec_ph1");
      step(0, 0, 1, 1, 0, 0, mk(0, 0, 0, 1, 0, n),  "exec_retire");
    end
  endtask

  task automatic instr(input int lg, input int ic);
    step(0, 1, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, ic), "fetch_ph1");
    step(0, 0, 1, 1, 0, 0, mk(1, 0, 1, 0, 0, ic), "fetch_tick");
    decode_exec(lg, ic);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 1, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset_hold");
    step(1, 0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset_hold_tick");

    for (int i = 0; i < 3; i++) instr(0, i);

    instr(1, 3);
    instr(0, 4);

    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 5), "stall_ph1");
      step(0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 5), "stall_tick");
    end
    step(0, 1, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 5), "ready_ph1");
    step(0, 0, 1, 1, 0, 0, mk(1, 0, 1, 0, 0, 5), "ready_tick");
    decode_exec(0, 5);

    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1, 0, 1, mk(0, 1, 0, 0, (i > 0) ? 1 : 0, 6), "halt_ph1");
      step(0, 0, 1, 1, 0, 1, mk(0, 0, 0, 0, 1, 6), "halt_tick");
    end
    step(0, 1, 0, 1, 0, 0, mk(0, 1, 0, 0, 1, 6), "unhalt_ph1");
    step(0, 0, 1, 1, 0, 0, mk(1, 0, 1, 0, 0, 6), "unhalt_tick");
    decode_exec(0, 6);

    step(0, 1, 1, 1, 0, 0, mk(1, 0, 1, 0, 0, 7), "overlap_tick");
    step(0, 0, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 7), "overlap_idle");
    decode_exec(0, 7);

    step(1, 0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset2");
    for (int i = 0; i < 17; i++) instr(0, i % 16);

    step(0, 1, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 1), "pre_abort_fetch_ph1");
    step(0, 0, 1, 1, 0, 0, mk(1, 0, 1, 0, 0, 1), "pre_abort_fetch_tick");
    step(0, 1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 1), "pre_abort_decode_ph1");
    step(0, 0, 1, 1, 0, 0, mk(2, 0, 0, 0, 0, 1), "pre_abort_decode_tick");
    @(negedge clk);
    ph1 = 1'b0;
    ph2 = 1'b1;
    #1;
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    name_q.push_back("async_reset_exec");
    -> chk_ev;
    @(posedge clk);
    step(1, 0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset_no_wb");
    step(0, 0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0), "post_reset_idle");
    instr(0, 0);

    @(negedge clk);
    #2;
    n_checks++;
    if (icount !== 4'd1) begin
      n_fail++;
      $display("FAIL final_icount: got %0d, expected 1", icount);
    end
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL final_state: got %b, expected 00", state);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
